// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter and its input conditioning.
// Defaults must track the divider chain so the monitor agrees with what it watches.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int EXPECT_DEF  = 2000;
    localparam int TIMEOUT_DEF = 4000;
    localparam int SYNC_STAGES = 2;

    // Lower tolerance bound, clamped so a wide TOL never goes negative.
    function automatic int lo_bound(input int expect_val, input int tol_val);
        return (expect_val > tol_val) ? (expect_val - tol_val) : 0;
    endfunction

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// Two-flop synchronizer plus delay register producing a one-cycle rising-edge pulse.
// Usable for any asynchronous level input (buttons, divided clocks, strobes).
module sync_edge_det
    import period_meter_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_reg;
    logic              delay_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= '0;
            delay_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[STAGES-2:0], async_in};
            delay_reg <= sync_reg[STAGES-1];
        end
    end

    assign rise = sync_reg[STAGES-1] & ~delay_reg;

endmodule

// File: rtl/period_meter.sv
// Measures the rising-edge period of a slow asynchronous signal in clk_in cycles,
// flags stalls and reports lock when the period stays within tolerance.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W   = 12,
    parameter int EXPECT  = EXPECT_DEF,
    parameter int TOL     = 20,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic             locked
);

    localparam int MW = $clog2(LOCK_N + 1);

    localparam logic [CNT_W:0]   LO_LIM   = (CNT_W+1)'(lo_bound(EXPECT, TOL));
    localparam logic [CNT_W:0]   HI_LIM   = (CNT_W+1)'(EXPECT + TOL);
    localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_N);
    localparam logic [MW-1:0]    M_ONE    = MW'(1);

    logic rise;

    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic             pv_reg,     pv_next;
    logic             tmo_reg,    tmo_next;
    logic             locked_reg, locked_next;
    logic [MW-1:0]    match_reg,  match_next;
    logic             in_range;

    sync_edge_det u_sync (
        .clk      (clk_in),
        .rst      (rst),
        .async_in (sig_in),
        .rise     (rise)
    );

    // One extra bit keeps the upper bound meaningful when EXPECT+TOL overflows CNT_W.
    assign in_range = ({1'b0, cnt_reg} >= LO_LIM) && ({1'b0, cnt_reg} <= HI_LIM);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        period_next = period_reg;
        pv_next     = 1'b0;
        tmo_next    = 1'b0;
        locked_next = locked_reg;
        match_next  = match_reg;

        if (!en) begin
            state_next  = IDLE;
            cnt_next    = '0;
            match_next  = '0;
            locked_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_next   = '0;
                    state_next = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_next   = CNT_ONE;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge landing on the timeout cycle still counts as a period.
                    if (rise) begin
                        period_next = cnt_reg;
                        pv_next     = 1'b1;
                        cnt_next    = CNT_ONE;
                        if (in_range) begin
                            match_next  = (match_reg >= LOCK_MAX) ? LOCK_MAX : (match_reg + M_ONE);
                            locked_next = (match_next == LOCK_MAX);
                        end else begin
                            match_next  = '0;
                            locked_next = 1'b0;
                        end
                    end else if (cnt_reg == TMO_CNT) begin
                        tmo_next    = 1'b1;
                        locked_next = 1'b0;
                        match_next  = '0;
                        cnt_next    = '0;
                        state_next  = ARM;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            period_reg <= '0;
            pv_reg     <= 1'b0;
            tmo_reg    <= 1'b0;
            locked_reg <= 1'b0;
            match_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            period_reg <= period_next;
            pv_reg     <= pv_next;
            tmo_reg    <= tmo_next;
            locked_reg <= locked_next;
            match_reg  <= match_next;
        end
    end

    assign period       = period_reg;
    assign period_valid = pv_reg;
    assign timeout      = tmo_reg;
    assign locked       = locked_reg;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench: each driven rising edge predicts its report (cycle, period, lock),
// and a negedge monitor pops and compares every period_valid / timeout pulse.
`timescale 1ns/1ps
module tb_period_meter;

    localparam int CNT_W   = 12;
    localparam int EXPECT  = 2000;
    localparam int TOL     = 20;
    localparam int LOCK_N  = 4;
    localparam int TIMEOUT = 4000;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic             en     = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             timeout;
    logic             locked;

    period_meter #(
        .CNT_W   (CNT_W),
        .EXPECT  (EXPECT),
        .TOL     (TOL),
        .LOCK_N  (LOCK_N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .en           (en),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout),
        .locked       (locked)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        int per;
        int lk;
    } exp_t;

    exp_t exp_q[$];
    int   tmo_q[$];
    exp_t mon_e;
    int   mon_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    int armed       = 0;
    int match       = 0;
    int last_rise   = 0;
    int last_period = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // A rise driven in interval T reaches period_valid in interval T+3.
    task automatic note_rise();
        int   gap;
        exp_t e;
        if (armed == 0) begin
            armed = 1;
        end else begin
            gap = cyc - last_rise;
            if (gap >= EXPECT - TOL && gap <= EXPECT + TOL)
                match = (match < LOCK_N) ? match + 1 : LOCK_N;
            else
                match = 0;
            e.cyc = cyc + 3;
            e.per = gap;
            e.lk  = (match == LOCK_N) ? 1 : 0;
            exp_q.push_back(e);
            last_period = gap;
        end
        last_rise = cyc;
    endtask

    task automatic run_periods(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            sig_in = 1'b1;
            note_rise();
            repeat (p / 2) tick();
            sig_in = 1'b0;
            repeat (p - p / 2 - 1) tick();
        end
    endtask

    always @(negedge clk_in) begin
        if (period_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_pv", period_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("pv_cycle", cyc, mon_e.cyc);
                check_val("period", period, mon_e.per);
                check_val("locked_at_pv", locked, mon_e.lk);
                $display("report cyc=%0d period=%0d locked=%0d", cyc, period, locked);
            end
        end
        if (timeout === 1'b1) begin
            if (tmo_q.size() == 0) begin
                check_val("unexpected_timeout", timeout, 0);
            end else begin
                mon_t = tmo_q.pop_front();
                check_val("timeout_cycle", cyc, mon_t);
                check_val("locked_at_timeout", locked, 0);
                $display("timeout cyc=%0d locked=%0d", cyc, locked);
            end
        end
    end

    initial begin
        // Reset held for three cycles with sig_in toggling
        for (int i = 0; i < 3; i++) begin
            sig_in = ~sig_in;
            tick();
            check_val("rst_period", period, 0);
            check_val("rst_pv", period_valid, 0);
            check_val("rst_timeout", timeout, 0);
            check_val("rst_locked", locked, 0);
        end
        rst    = 1'b0;
        sig_in = 1'b0;
        tick();
        check_val("rel_period", period, 0);
        check_val("rel_pv", period_valid, 0);
        check_val("rel_timeout", timeout, 0);
        check_val("rel_locked", locked, 0);

        en = 1'b1;
        repeat (20) tick();

        // Nominal period: lock on the fourth report and hold
        run_periods(2000, 6);

        // Out-of-tolerance period breaks lock, then relock
        run_periods(2021, 1);
        run_periods(2000, 5);

        // Stall while locked
        tick();
        sig_in = 1'b1;
        note_rise();
        repeat (1000) tick();
        sig_in = 1'b0;
        tmo_q.push_back(last_rise + TIMEOUT + 3);
        armed = 0;
        match = 0;
        repeat (4200) tick();
        check_val("stall_locked", locked, 0);
        run_periods(2000, 3);

        // Tolerance boundaries
        run_periods(1980, 4);
        run_periods(2020, 4);
        run_periods(1979, 1);
        run_periods(2000, 2);

        // Enable dropped mid-period
        tick();
        sig_in = 1'b1;
        note_rise();
        repeat (1000) tick();
        sig_in = 1'b0;
        repeat (500) tick();
        en    = 1'b0;
        armed = 0;
        match = 0;
        repeat (10) tick();
        check_val("en_off_locked", locked, 0);
        check_val("en_off_period", period, last_period);
        check_val("en_off_pv", period_valid, 0);
        en = 1'b1;
        repeat (489) tick();
        run_periods(2000, 3);

        // Reset pulsed mid-period
        tick();
        sig_in = 1'b1;
        note_rise();
        repeat (1000) tick();
        sig_in = 1'b0;
        repeat (500) tick();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        armed       = 0;
        match       = 0;
        last_period = 0;
        tick();
        check_val("rst_mid_period", period, 0);
        check_val("rst_mid_locked", locked, 0);
        repeat (497) tick();
        run_periods(2000, 3);

        repeat (20) tick();
        check_val("reports_pending", exp_q.size(), 0);
        check_val("timeouts_pending", tmo_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
